// File: rtl/ldst_bank_arbiter.sv
// Warp-wide L1 load/store bank arbiter: serializes a request into conflict-free passes.
// Optional macro LDST_ARB_BROADCAST_EN coalesces same-bank, same-row lanes into one pass.
module ldst_bank_arbiter #(
  parameter int SP_PER_MP     = 8,
  parameter int NUM_BANKS     = 8,
  parameter int L1_ADDR_WIDTH = 10,
  parameter int BANK_WIDTH    = $clog2(NUM_BANKS),
  parameter int ROW_WIDTH     = L1_ADDR_WIDTH - BANK_WIDTH,
  parameter int PASS_WIDTH    = $clog2(SP_PER_MP + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [L1_ADDR_WIDTH-1:0] req_addrs [SP_PER_MP],
  input  logic [SP_PER_MP-1:0]     req_mask,
  output logic                     issue_valid,
  input  logic                     bank_ready,
  output logic [NUM_BANKS-1:0]     bank_en,
  output logic [ROW_WIDTH-1:0]     bank_row [NUM_BANKS],
  output logic [SP_PER_MP-1:0]     lane_grant,
  output logic                     done,
  output logic [PASS_WIDTH-1:0]    pass_count,
  output logic                     contention
);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                     state, state_next;
  logic [L1_ADDR_WIDTH-1:0]   addrs [SP_PER_MP];
  logic [SP_PER_MP-1:0]       pending, pending_next;
  logic [PASS_WIDTH-1:0]      count, count_inc;
  logic                       found;
  logic                       retire;

  assign req_ready    = (state == IDLE);
  assign issue_valid  = (state == ISSUE);
  assign retire       = issue_valid & bank_ready;
  assign pending_next = pending & ~lane_grant;
  assign count_inc    = count + PASS_WIDTH'(1);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (req_valid && (req_mask != '0)) state_next = ISSUE;
      ISSUE:   if (retire && (pending_next == '0)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: the address store is deliberately not reset; only lanes marked in pending are ever read.
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) addrs <= req_addrs;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending    <= '0;
      count      <= '0;
      done       <= 1'b0;
      pass_count <= '0;
      contention <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (req_valid) begin
          pending <= req_mask;
          count   <= '0;
          if (req_mask == '0) begin
            done       <= 1'b1;
            pass_count <= '0;
            contention <= 1'b0;
          end
        end
      end else if (retire) begin
        pending <= pending_next;
        count   <= count_inc;
        if (pending_next == '0) begin
          done       <= 1'b1;
          pass_count <= count_inc;
          contention <= (count_inc > PASS_WIDTH'(1));
        end
      end
    end
  end

  // Per-bank leader search runs for all banks in parallel; lowest pending lane wins.
  always_comb begin
    bank_en    = '0;
    lane_grant = '0;
    found      = 1'b0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      bank_row[b] = '0;
      found       = 1'b0;
      for (int l = 0; l < SP_PER_MP; l++) begin
        if (issue_valid && !found && pending[l] &&
            (addrs[l][BANK_WIDTH-1:0] == BANK_WIDTH'(b))) begin
          found         = 1'b1;
          bank_en[b]    = 1'b1;
          bank_row[b]   = addrs[l][L1_ADDR_WIDTH-1:BANK_WIDTH];
          lane_grant[l] = 1'b1;
        end
      end
`ifdef LDST_ARB_BROADCAST_EN
      // Followers reading the leader's exact row ride along in the same pass.
      for (int l = 0; l < SP_PER_MP; l++) begin
        if (bank_en[b] && pending[l] &&
            (addrs[l][BANK_WIDTH-1:0] == BANK_WIDTH'(b)) &&
            (addrs[l][L1_ADDR_WIDTH-1:BANK_WIDTH] == bank_row[b]))
          lane_grant[l] = 1'b1;
      end
`endif
    end
  end

endmodule
